display_capture: RTL and testbench

DISPLAY_CAPTURE -- requirements
Module: display_capture

---
 rtl/display_pkg.sv | 58 +++++
 rtl/seg_decoder.sv | 31 +++
 rtl/display_capture.sv | 133 +++++++++++++
 tb/tb_display_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display definitions: hex segment table, digit count, segment
// indices, anode one-cold codes and the registered bus sample type.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bit positions within the 7-bit segment bus (a = bit 0).
  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_idx_e;

  // One-cold anode codes; digit 3 is the leftmost digit.
  localparam logic [3:0] AN_DIGIT0 = 4'b1110;
  localparam logic [3:0] AN_DIGIT1 = 4'b1101;
  localparam logic [3:0] AN_DIGIT2 = 4'b1011;
  localparam logic [3:0] AN_DIGIT3 = 4'b0111;

  // Active-high lit segments {g,f,e,d,c,b,a} for hex 0..F (b and d lowercase).
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One registered snapshot of the display bus (all fields active-low).
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } sample_t;

  localparam sample_t SAMPLE_IDLE = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

  // True when exactly one digit is enabled.
  function automatic logic an_is_digit(input logic [3:0] an);
    return (an == AN_DIGIT0) || (an == AN_DIGIT1) ||
           (an == AN_DIGIT2) || (an == AN_DIGIT3);
  endfunction

  // Slot index of the enabled digit; only meaningful when an_is_digit holds.
  function automatic logic [1:0] an_slot(input logic [3:0] an);
    logic [1:0] slot;
    slot = 2'd0;
    case (an)
      AN_DIGIT1: slot = 2'd1;
      AN_DIGIT2: slot = 2'd2;
      AN_DIGIT3: slot = 2'd3;
      default:   slot = 2'd0;
    endcase
    return slot;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational decode of an active-low 7-segment pattern back to a hex nibble.
module seg_decoder
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit
);

  logic [6:0]  seg_on;
  logic [15:0] match;

  assign seg_on = ~seg;

  for (genvar gi = 0; gi < 16; gi++) begin : g_match
    assign match[gi] = (seg_on == SEG_TABLE[gi]);
  end

  // Table entries are distinct, so at most one match bit is ever set.
  always_comb begin
    nibble = 4'h0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (match[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_capture.sv
// Reads a multiplexed 4-digit 7-segment scan and rebuilds the 16-bit hex
// value and decimal-point mask it shows. A digit is captured once after it
// has been stable for STABLE_CYCLES samples; a frame is published once all
// four digit slots have been captured.
module display_capture
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [15:0] value,
  output logic [3:0]  dp_mask,
  output logic        value_valid,
  output logic        digit_err
);

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  sample_t sample_reg;
  sample_t prev_reg;
  logic [7:0] dwell_reg;
  logic sample_digit;
  logic sample_same;
  logic capture;

  logic [3:0] dec_nibble;
  logic       dec_hit;

  logic       cap_reg;
  logic       cap_hit_reg;
  logic [3:0] cap_nibble_reg;
  logic [1:0] cap_slot_reg;
  logic       cap_dp_reg;

  logic [3:0]            slot_nib_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] slot_dp_reg;
  logic [NUM_DIGITS-1:0] seen_reg;
  logic [NUM_DIGITS-1:0] seen_next;
  logic                  frame_done;
  logic [15:0]           assembled;

  assign sample_digit = an_is_digit(sample_reg.an);
  assign sample_same  = (sample_reg == prev_reg);
  // Fires on the single edge where the dwell count reaches the limit.
  assign capture      = sample_digit && sample_same && (dwell_reg == STABLE_LIMIT - 8'd1);
  assign frame_done   = (seen_reg == {NUM_DIGITS{1'b1}});

  seg_decoder u_dec (
    .seg    (sample_reg.seg),
    .nibble (dec_nibble),
    .hit    (dec_hit)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_assemble
    assign assembled[gi*4 +: 4] = slot_nib_reg[gi];
  end

  // Sample the bus once and count how long the current digit has held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_reg <= SAMPLE_IDLE;
      prev_reg   <= SAMPLE_IDLE;
      dwell_reg  <= 8'd0;
    end else begin
      sample_reg <= '{an: an, seg: seg, dp: dp};
      prev_reg   <= sample_reg;
      if (!sample_digit) begin
        dwell_reg <= 8'd0;
      end else if (!sample_same) begin
        dwell_reg <= 8'd1;
      end else if (dwell_reg < STABLE_LIMIT) begin
        dwell_reg <= dwell_reg + 8'd1;
      end
    end
  end

  // Decode register: latch the captured digit and flag undecodable patterns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_reg        <= 1'b0;
      cap_hit_reg    <= 1'b0;
      cap_nibble_reg <= 4'h0;
      cap_slot_reg   <= 2'd0;
      cap_dp_reg     <= 1'b0;
      digit_err      <= 1'b0;
    end else begin
      cap_reg        <= capture;
      cap_hit_reg    <= dec_hit;
      cap_nibble_reg <= dec_nibble;
      cap_slot_reg   <= an_slot(sample_reg.an);
      cap_dp_reg     <= ~sample_reg.dp;
      digit_err      <= capture && !dec_hit;
    end
  end

  // A completed frame clears the seen set; a capture landing the same cycle starts the next one.
  always_comb begin
    seen_next = frame_done ? '0 : seen_reg;
    if (cap_reg && cap_hit_reg) begin
      seen_next[cap_slot_reg] = 1'b1;
    end
  end

  // Slot storage and frame publication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        slot_nib_reg[i] <= 4'h0;
      end
      slot_dp_reg <= '0;
      seen_reg    <= '0;
      value       <= 16'h0000;
      dp_mask     <= 4'h0;
      value_valid <= 1'b0;
    end else begin
      seen_reg    <= seen_next;
      value_valid <= frame_done;
      if (frame_done) begin
        value   <= assembled;
        dp_mask <= slot_dp_reg;
      end
      if (cap_reg && cap_hit_reg) begin
        slot_nib_reg[cap_slot_reg] <= cap_nibble_reg;
        slot_dp_reg[cap_slot_reg]  <= cap_dp_reg;
      end
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: directed scans, with a per-edge event model
// that predicts value/dp_mask/value_valid/digit_err from the bus history.
module tb_display_capture;

  localparam int STABLE = 4;
  localparam int MAXE   = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic        dp = 1'b1;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        value_valid;
  logic        digit_err;

  display_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .value       (value),
    .dp_mask     (dp_mask),
    .value_valid (value_valid),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  // Lit segments {g..a} for each hex digit, as a display driver would emit them.
  logic [6:0] hex_lit [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int vv_cnt   = 0;
  int err_cnt  = 0;

  // Expected events, indexed by the clock edge after which they are visible.
  bit          ev_vv  [MAXE];
  logic [15:0] ev_val [MAXE];
  logic [3:0]  ev_msk [MAXE];
  bit          ev_err [MAXE];
  bit          ev_rst [MAXE];

  // Model state: the run of identical bus words and the partial frame.
  logic [11:0] prev_word;
  bit          have_prev = 0;
  int          run_len = 0;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_dp   = 4'h0;
  logic [3:0]  m_seen = 4'h0;

  logic [15:0] cur_val = 16'h0;
  logic [3:0]  cur_msk = 4'h0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, got, want);
    end
  endtask

  // Feed the bus word presented at edge n into the model.
  task automatic model_edge(input int n, input logic [3:0] a, input logic [6:0] s,
                            input logic d, input logic r);
    logic [11:0] word;
    int zeros, slot, nib;
    if (!r) begin
      for (int e = n; e < n + 4 && e < MAXE; e++) begin
        ev_vv[e] = 0;
        ev_err[e] = 0;
      end
      if (n < MAXE) ev_rst[n] = 1;
      have_prev = 0;
      run_len = 0;
      m_seen = 4'h0;
      return;
    end
    word = {a, s, d};
    zeros = 0;
    slot = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; slot = i; end
    if (zeros == 1 && have_prev && word == prev_word) run_len++;
    else run_len = (zeros == 1) ? 1 : 0;
    prev_word = word;
    have_prev = 1;
    if (zeros == 1 && run_len == STABLE) begin
      nib = -1;
      for (int i = 0; i < 16; i++) if (hex_lit[i] == ~s) nib = i;
      if (nib < 0) begin
        if (n + 1 < MAXE) ev_err[n+1] = 1;
      end else begin
        m_nib[slot] = 4'(nib);
        m_dp[slot] = ~d;
        m_seen[slot] = 1'b1;
        if (m_seen == 4'hF) begin
          if (n + 3 < MAXE) begin
            ev_vv[n+3]  = 1;
            ev_val[n+3] = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            ev_msk[n+3] = m_dp;
          end
          m_seen = 4'h0;
        end
      end
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Compare every output against the model after each edge.
  always @(negedge clk) begin
    if (edge_cnt > 0 && edge_cnt < MAXE) begin
      if (ev_rst[edge_cnt]) begin
        cur_val = 16'h0;
        cur_msk = 4'h0;
      end else if (ev_vv[edge_cnt]) begin
        cur_val = ev_val[edge_cnt];
        cur_msk = ev_msk[edge_cnt];
      end
      check("value", value, cur_val);
      check("dp_mask", {12'h0, dp_mask}, {12'h0, cur_msk});
      check("value_valid", {15'h0, value_valid}, {15'h0, ev_vv[edge_cnt]});
      check("digit_err", {15'h0, digit_err}, {15'h0, ev_err[edge_cnt]});
      if (value_valid === 1'b1) vv_cnt++;
      if (digit_err === 1'b1) err_cnt++;
    end
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input logic r);
    @(negedge clk);
    an = a;
    seg = s;
    dp = d;
    rst_n = r;
    model_edge(edge_cnt + 1, a, s, d, r);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(4'hF, 7'h7F, 1'b1, 1'b1);
  endtask

  task automatic digit_raw(input int slot, input logic [6:0] s, input logic d, input int cycles);
    logic [3:0] a;
    a = 4'hF;
    a[slot] = 1'b0;
    for (int i = 0; i < cycles; i++) drive(a, s, d, 1'b1);
  endtask

  task automatic digit(input int slot, input logic [3:0] nib, input logic d, input int cycles);
    digit_raw(slot, ~hex_lit[nib], d, cycles);
  endtask

  // One rotation an=E,D,B,7; dp is lit only on dp_slot (-1 for none).
  task automatic scan(input logic [15:0] v, input int dwell, input int dp_slot);
    for (int k = 0; k < 4; k++) digit(k, v[k*4 +: 4], (k == dp_slot) ? 1'b0 : 1'b1, dwell);
  endtask

  initial begin
    model_edge(1, 4'hF, 7'h7F, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(4'hF, 7'h7F, 1'b1, 1'b0);
    idle(2);
    check("reset_value", value, 16'h0000);
    check("reset_dp_mask", {12'h0, dp_mask}, 16'h0000);

    // Dwell one short of the limit never captures.
    scan(16'h1234, 3, -1);
    scan(16'h1234, 3, -1);
    idle(6);
    check("short_dwell_value", value, 16'h0000);
    check("short_dwell_pulses", 16'(vv_cnt), 16'd0);

    // Two normal scans publish two frames.
    scan(16'h1234, 8, -1);
    scan(16'h1234, 8, -1);
    idle(6);
    check("scan1234_value", value, 16'h1234);
    check("scan1234_pulses", 16'(vv_cnt), 16'd2);
    check("scan1234_errs", 16'(err_cnt), 16'd0);

    // Decimal point only on an=1011.
    scan(16'hABCD, 8, 2);
    idle(6);
    check("abcd_value", value, 16'hABCD);
    check("abcd_dp_mask", {12'h0, dp_mask}, 16'h0004);
    check("abcd_pulses", 16'(vv_cnt), 16'd3);

    // Multi-digit and blank anode codes interleaved are ignored.
    digit(0, 4'hF, 1'b1, 8);
    for (int i = 0; i < 20; i++) drive(4'b1100, ~hex_lit[5], 1'b1, 1'b1);
    digit(1, 4'h0, 1'b1, 8);
    for (int i = 0; i < 20; i++) drive(4'hF, ~hex_lit[5], 1'b1, 1'b1);
    digit(2, 4'hE, 1'b1, 8);
    digit(3, 4'h9, 1'b1, 8);
    idle(6);
    check("bad_anode_value", value, 16'h9E0F);
    check("bad_anode_dp_mask", {12'h0, dp_mask}, 16'h0000);
    scan(16'h9E0F, 8, -1);
    idle(6);
    check("bad_anode_pulses", 16'(vv_cnt), 16'd5);

    // Blank pattern on the leftmost digit: error pulse, frame waits for a legal digit.
    digit(0, 4'h4, 1'b1, 8);
    digit(1, 4'h3, 1'b1, 8);
    digit(2, 4'h2, 1'b1, 8);
    digit_raw(3, 7'h7F, 1'b1, 8);
    idle(4);
    check("blank_err_pulses", 16'(err_cnt), 16'd1);
    check("blank_no_frame", 16'(vv_cnt), 16'd5);
    digit(3, 4'h1, 1'b1, 8);
    idle(6);
    check("blank_recover_value", value, 16'h1234);
    check("blank_recover_pulses", 16'(vv_cnt), 16'd6);

    // Reset mid-frame discards captured slots.
    digit(1, 4'h3, 1'b1, 8);
    digit(2, 4'h2, 1'b1, 8);
    drive(4'hF, 7'h7F, 1'b1, 1'b0);
    idle(1);
    check("midreset_value", value, 16'h0000);
    digit(3, 4'h1, 1'b1, 8);
    digit(0, 4'h4, 1'b1, 8);
    idle(6);
    check("midreset_no_frame", 16'(vv_cnt), 16'd6);
    check("midreset_hold_value", value, 16'h0000);
    scan(16'h1234, 8, -1);
    idle(6);
    check("midreset_value_after", value, 16'h1234);
    check("midreset_pulses", 16'(vv_cnt), 16'd7);
    check("total_errs", 16'(err_cnt), 16'd1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
